// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Sits in front of a single-port 32-bit word RAM (combinational read,
//   write on the rising edge) and serves two requesters: instruction fetch
//   (IF, word reads only) and load/store (LS). One transaction takes three
//   cycles: IDLE (handshake), ACCESS (RAM cycle), RESP (one-cycle response).
//   Sub-word stores are merged with the current RAM word within the ACCESS
//   cycle, so the RAM only ever sees full-word writes.
//
// Ports
//   CLK, RESET                    clock, synchronous active-high reset
//   IF_REQ_VALID/READY, IF_ADDR   fetch request (byte address)
//   IF_RSP_VALID/DATA/ERROR       fetch response, one-cycle pulse
//   LS_REQ_VALID/READY, LS_ADDR,
//   LS_WRITE, LS_FUNCT3, LS_WDATA load/store request (RV32 width codes)
//   LS_RSP_VALID/DATA/ERROR       load/store response, one-cycle pulse
//   RAM_ADDRESS, RAM_DATA_IN,
//   RAM_WRITE_ENABLE, RAM_DATA_OUT  RAM interface
module ram_access_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IF_REQ_VALID,
  output logic                  IF_REQ_READY,
  input  logic [31:0]           IF_ADDR,
  output logic                  IF_RSP_VALID,
  output logic [31:0]           IF_RSP_DATA,
  output logic                  IF_RSP_ERROR,
  input  logic                  LS_REQ_VALID,
  output logic                  LS_REQ_READY,
  input  logic [31:0]           LS_ADDR,
  input  logic                  LS_WRITE,
  input  logic [2:0]            LS_FUNCT3,
  input  logic [31:0]           LS_WDATA,
  output logic                  LS_RSP_VALID,
  output logic [31:0]           LS_RSP_DATA,
  output logic                  LS_RSP_ERROR,
  output logic [ADDR_WIDTH-1:0] RAM_ADDRESS,
  output logic [31:0]           RAM_DATA_IN,
  output logic                  RAM_WRITE_ENABLE,
  input  logic [31:0]           RAM_DATA_OUT
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state;
  logic                    last_ls;
  logic                    grant_if;
  logic                    grant_ls;
  logic                    handshake;
  logic [31:0]             sel_addr;
  logic                    sel_write;
  logic [2:0]              sel_f3;
  logic [31:0]             load_data;

  logic                    is_ls_p1;
  logic [ADDR_WIDTH-1:0]   word_addr_p1;
  logic [1:0]              off_p1;
  logic                    write_p1;
  logic [2:0]              f3_p1;
  logic [31:0]             wdata_p1;
  logic                    err_p1;

  // Fault classification of a request: out-of-range address, misalignment,
  // reserved width codes, and unsigned widths used on a store.
  function automatic logic access_error(input logic [31:0] addr,
                                        input logic        write,
                                        input logic [2:0]  f3);
    logic bad;
    bad = ((addr >> (ADDR_WIDTH + 2)) != 32'd0);
    case (f3)
      3'b000:  bad = bad;
      3'b100:  bad = bad | write;
      3'b001:  bad = bad | addr[0];
      3'b101:  bad = bad | addr[0] | write;
      3'b010:  bad = bad | (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Replace the addressed byte/halfword lanes of the old word with the
  // right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] mask;
    logic [4:0]  sh;
    sh = {off, 3'b000};
    case (f3[1:0])
      2'b00:   mask = 32'h0000_00FF;
      2'b01:   mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old_word & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // Shift the addressed lane down to bit 0 and extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return s;
    endcase
  endfunction

  // Round-robin: on a tie, the requester not granted last time wins.
  always_comb begin
    grant_if     = IF_REQ_VALID && (!LS_REQ_VALID || last_ls);
    grant_ls     = LS_REQ_VALID && !grant_if;
    IF_REQ_READY = (state == IDLE) && !RESET && grant_if;
    LS_REQ_READY = (state == IDLE) && !RESET && grant_ls;
    handshake    = IF_REQ_READY || LS_REQ_READY;
    sel_addr     = grant_if ? IF_ADDR : LS_ADDR;
    sel_write    = grant_if ? 1'b0 : LS_WRITE;
    sel_f3       = grant_if ? 3'b010 : LS_FUNCT3;
  end

  // ACCESS stage: RAM read data is valid this cycle; writes commit at its end.
  always_comb begin
    RAM_ADDRESS      = word_addr_p1;
    RAM_DATA_IN      = store_merge(RAM_DATA_OUT, wdata_p1, f3_p1, off_p1);
    RAM_WRITE_ENABLE = (state == ACCESS) && write_p1 && !err_p1 && !RESET;
    load_data        = (err_p1 || write_p1) ? 32'd0
                                            : load_extract(RAM_DATA_OUT, f3_p1, off_p1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      last_ls      <= 1'b1;
      word_addr_p1 <= '0;
      IF_RSP_VALID <= 1'b0;
      IF_RSP_DATA  <= 32'd0;
      IF_RSP_ERROR <= 1'b0;
      LS_RSP_VALID <= 1'b0;
      LS_RSP_DATA  <= 32'd0;
      LS_RSP_ERROR <= 1'b0;
    end else begin
      case (state)
        // IDLE -> p1: capture the granted request
        IDLE: begin
          if (handshake) begin
            state        <= ACCESS;
            last_ls      <= LS_REQ_READY;
            is_ls_p1     <= LS_REQ_READY;
            word_addr_p1 <= sel_addr[ADDR_WIDTH+1:2];
            off_p1       <= sel_addr[1:0];
            write_p1     <= sel_write;
            f3_p1        <= sel_f3;
            wdata_p1     <= LS_WDATA;
            err_p1       <= access_error(sel_addr, sel_write, sel_f3);
          end
        end
        // ACCESS -> RESP: register the response for the captured requester
        ACCESS: begin
          state <= RESP;
          if (is_ls_p1) begin
            LS_RSP_VALID <= 1'b1;
            LS_RSP_DATA  <= load_data;
            LS_RSP_ERROR <= err_p1;
          end else begin
            IF_RSP_VALID <= 1'b1;
            IF_RSP_DATA  <= load_data;
            IF_RSP_ERROR <= err_p1;
          end
        end
        // RESP -> IDLE: response pulse ends
        default: begin
          state        <= IDLE;
          IF_RSP_VALID <= 1'b0;
          IF_RSP_DATA  <= 32'd0;
          IF_RSP_ERROR <= 1'b0;
          LS_RSP_VALID <= 1'b0;
          LS_RSP_DATA  <= 32'd0;
          LS_RSP_ERROR <= 1'b0;
        end
      endcase
    end
  end

endmodule
